hazard_stall_sequencer: RTL

- Sequencing controller for the IF/ID pipeline-control datapath: PC write enable, IF/ID register write, ID/EX control bubble mux and IF/ID flush.
- Arbitrates between three sources and emits the four control lines every cycle:
  - redirect/flush requests (taken branch, resolved JR);
  - fixed-latency multi-cycle mult/div occupancy;
  - per-cycle dependency stalls from hazard detection.
- Adds a multi-cycle flush window, a mult/div wait FSM, a stall watchdog and saturating performance counters.
- Sits between the hazard detection logic and the PC / IF-ID / ID-EX registers.

---
 rtl/hazard_stall_sequencer_pkg.sv | 41 ++++
 rtl/hazard_stall_sequencer_sat_counter.sv | 38 +++
 rtl/hazard_stall_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_sequencer_pkg.sv
// Shared definitions for the IF/ID pipeline-control sequencer and the hazard
// detection logic that feeds it.
//   - state_e      : sequencer state encoding
//   - Ctrl*        : 4-bit control vectors {PCWrite, DecodeRegWrite, MuxControl, flushControl}
//   - Opcode/Funct : mult/div and JR decode constants shared with hazard detection
//   - cnt_width()  : width of the shared flush / mult-div down-counter
package hazard_stall_sequencer_pkg;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StFlush  = 2'd1,
        StMuldiv = 2'd2
    } state_e;

    localparam logic [3:0] CtrlStall  = 4'b0000;
    localparam logic [3:0] CtrlFlush  = 4'b1111;
    localparam logic [3:0] CtrlNormal = 4'b1110;

    localparam logic [5:0] OpcodeRtype = 6'b000000;
    localparam logic [5:0] FunctJr     = 6'b001000;
    localparam logic [5:0] FunctMult   = 6'b011000;
    localparam logic [5:0] FunctMultu  = 6'b011001;
    localparam logic [5:0] FunctDiv    = 6'b011010;
    localparam logic [5:0] FunctDivu   = 6'b011011;

    // R-type mult/div decode, used by hazard detection to raise muldiv_start.
    function automatic logic is_muldiv(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OpcodeRtype) &&
               ((funct == FunctMult) || (funct == FunctMultu) ||
                (funct == FunctDiv)  || (funct == FunctDivu));
    endfunction

    // clog2 of the larger latency, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned muldiv_lat,
                                              input int unsigned flush_cycles);
        int unsigned max_lat;
        max_lat = (muldiv_lat > flush_cycles) ? muldiv_lat : flush_cycles;
        return (max_lat > 2) ? $clog2(max_lat) : 1;
    endfunction

endpackage

// File: rtl/hazard_stall_sequencer_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous reset, active-high (count -> 0)
//   inc_i   : add one this cycle (held at all-ones once reached)
//   clear_i : synchronous clear, wins over inc_i
//   count_o : current count
module hazard_stall_sequencer_sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {Width{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_sequencer.sv
// IF/ID pipeline-control sequencer. Arbitrates redirects, fixed-latency
// mult/div occupancy and per-cycle dependency stalls into the four control
// lines of the PC / IF-ID / ID-EX registers, and keeps a stall watchdog plus
// saturating performance counters.
//   Clk, Reset     : clock (rising edge), synchronous active-high reset
//   dep_stall      : dependency stall request from hazard detection
//   redirect       : taken branch / resolved JR this cycle
//   muldiv_start   : mult/div issuing from decode this cycle
//   PCWrite        : PC write enable
//   DecodeRegWrite : IF/ID write enable
//   MuxControl     : 1 = pass decode controls, 0 = bubble into ID/EX
//   flushControl   : clear IF/ID
//   muldiv_done    : pulse in the last mult/div stall cycle
//   stall_timeout  : sticky watchdog flag
//   stall_cycles   : saturating count of cycles with PCWrite = 0
//   flush_events   : saturating count of accepted redirects
module hazard_stall_sequencer
    import hazard_stall_sequencer_pkg::*;
#(
    parameter int unsigned MULDIV_LAT   = 4,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_STALL    = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             dep_stall,
    input  logic             redirect,
    input  logic             muldiv_start,
    output logic             PCWrite,
    output logic             DecodeRegWrite,
    output logic             MuxControl,
    output logic             flushControl,
    output logic             muldiv_done,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int unsigned CntW = cnt_width(MULDIV_LAT, FLUSH_CYCLES);
    localparam int unsigned WdW  = $clog2(MAX_STALL + 1);

    // The cycle that enters FLUSH/MULDIV is already the first window cycle,
    // and the counter expires one cycle after reaching zero, hence the -2.
    localparam logic [CntW-1:0] MuldivReload = CntW'(MULDIV_LAT - 2);
    localparam logic [CntW-1:0] FlushReload  =
        (FLUSH_CYCLES > 1) ? CntW'(FLUSH_CYCLES - 2) : '0;
    localparam logic [WdW-1:0]  WdLast       = WdW'(MAX_STALL - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    logic [3:0]      ctrl;
    logic            flush_acc;
    logic            done_raw;
    logic            wd_inc;
    logic            wd_hit;
    logic [WdW-1:0]  wd_count;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl      = CtrlNormal;
        flush_acc = 1'b0;
        done_raw  = 1'b0;
        wd_inc    = 1'b0;

        unique case (state_q)
            StRun: begin
                if (redirect) begin
                    ctrl      = CtrlFlush;
                    flush_acc = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = StFlush;
                        cnt_d   = FlushReload;
                    end
                end else if (muldiv_start) begin
                    // A coincident dep_stall is covered by the mult/div stall.
                    ctrl    = CtrlStall;
                    state_d = StMuldiv;
                    cnt_d   = MuldivReload;
                end else if (dep_stall) begin
                    ctrl   = CtrlStall;
                    wd_inc = 1'b1;
                end
            end

            StFlush: begin
                ctrl = CtrlFlush;
                if (redirect) begin
                    flush_acc = 1'b1;
                    cnt_d     = FlushReload;
                end else if (cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            StMuldiv: begin
                // Upstream must not raise requests here; they are dropped.
                ctrl = CtrlStall;
                if (cnt_q == '0) begin
                    done_raw = 1'b1;
                    state_d  = StRun;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    // Timeout is raised on the edge where the watchdog reaches MAX_STALL.
    assign wd_hit    = wd_inc && (wd_count >= WdLast);
    assign timeout_d = timeout_q | wd_hit;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign {PCWrite, DecodeRegWrite, MuxControl, flushControl} = ctrl;

    // A reset that lands in the last mult/div cycle abandons the operation.
    assign muldiv_done   = done_raw & ~Reset;
    assign stall_timeout = timeout_q;

    hazard_stall_sequencer_sat_counter #(
        .Width (CNT_W)
    ) u_stall_cycles (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .inc_i   (~ctrl[3]),
        .clear_i (1'b0),
        .count_o (stall_cycles)
    );

    hazard_stall_sequencer_sat_counter #(
        .Width (CNT_W)
    ) u_flush_events (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .inc_i   (flush_acc),
        .clear_i (1'b0),
        .count_o (flush_events)
    );

    // Consecutive plain dependency-stall cycles; anything else restarts it.
    hazard_stall_sequencer_sat_counter #(
        .Width (WdW)
    ) u_watchdog (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .inc_i   (wd_inc),
        .clear_i (~wd_inc),
        .count_o (wd_count)
    );

endmodule
